hazard_stall_unit: RTL

//   Decode-stage consumer of the per-operand T_use values produced by the IF/ID register. Tracks the

---
 rtl/hazard_stall_unit.sv | 99 +++++++++
 1 files changed

// File: rtl/hazard_stall_unit.sv
// Decode-stage stall/flush generator: tracks E/M destination + T_new and a mult/div busy window.
// Stall is combinational (zero latency) from D inputs and tracked state; tracking advances every edge.
module hazard_stall_unit #(
    parameter int ADDR_W     = 5,
    parameter int TUSE_W     = 5,
    parameter int TNEW_W     = 2,
    parameter int MULT_DELAY = 5,
    parameter int DIV_DELAY  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] D_rs,
    input  logic [ADDR_W-1:0] D_rt,
    input  logic [TUSE_W-1:0] D_T_use_rs,
    input  logic [TUSE_W-1:0] D_T_use_rt,
    input  logic [ADDR_W-1:0] D_wr_addr,
    input  logic [TNEW_W-1:0] D_T_new,
    input  logic              D_uses_md,
    input  logic [1:0]        E_md_start,
    output logic              stall,
    output logic              flush_E,
    output logic [ADDR_W-1:0] E_wr_addr,
    output logic [TNEW_W-1:0] E_T_new,
    output logic [ADDR_W-1:0] M_wr_addr,
    output logic [TNEW_W-1:0] M_T_new,
    output logic              md_busy
);

    localparam int MD_W = ($clog2(DIV_DELAY + 1) > 4) ? $clog2(DIV_DELAY + 1) : 4;
    localparam logic [MD_W-1:0] MULT_LD = MD_W'(MULT_DELAY);
    localparam logic [MD_W-1:0] DIV_LD  = MD_W'(DIV_DELAY);

    logic [ADDR_W-1:0] E_wr_q, E_wr_d;
    logic [TNEW_W-1:0] E_tn_q, E_tn_d;
    logic [ADDR_W-1:0] M_wr_q, M_wr_d;
    logic [TNEW_W-1:0] M_tn_q, M_tn_d;
    logic [MD_W-1:0]   md_cnt_q, md_cnt_d;

    logic [TUSE_W-1:0] E_tn_ext, M_tn_ext;
    logic rs_haz_e, rs_haz_m, rt_haz_e, rt_haz_m, md_haz;

    assign E_tn_ext = TUSE_W'(E_tn_q);
    assign M_tn_ext = TUSE_W'(M_tn_q);
    assign md_busy  = (md_cnt_q != '0);

    // T_use of all-ones exceeds any T_new, so unused operands never match.
    assign rs_haz_e = (D_rs != '0) && (D_rs == E_wr_q) && (D_T_use_rs < E_tn_ext);
    assign rs_haz_m = (D_rs != '0) && (D_rs == M_wr_q) && (D_T_use_rs < M_tn_ext);
    assign rt_haz_e = (D_rt != '0) && (D_rt == E_wr_q) && (D_T_use_rt < E_tn_ext);
    assign rt_haz_m = (D_rt != '0) && (D_rt == M_wr_q) && (D_T_use_rt < M_tn_ext);
    assign md_haz   = D_uses_md && (md_busy || (E_md_start != 2'b00));

    assign stall   = rs_haz_e | rs_haz_m | rt_haz_e | rt_haz_m | md_haz;
    assign flush_E = stall;

    assign E_wr_addr = E_wr_q;
    assign E_T_new   = E_tn_q;
    assign M_wr_addr = M_wr_q;
    assign M_T_new   = M_tn_q;

    always_comb begin
        M_wr_d = E_wr_q;
        M_tn_d = (E_tn_q == '0) ? '0 : E_tn_q - TNEW_W'(1);
        if (stall) begin
            E_wr_d = '0;
            E_tn_d = '0;
        end else begin
            E_wr_d = D_wr_addr;
            E_tn_d = D_T_new;
        end
    end

    // A new start always reloads, even mid-window; the illegal code 11 is treated as no start.
    always_comb begin
        md_cnt_d = md_cnt_q;
        case (E_md_start)
            2'b01:   md_cnt_d = MULT_LD;
            2'b10:   md_cnt_d = DIV_LD;
            default: if (md_cnt_q != '0) md_cnt_d = md_cnt_q - MD_W'(1);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            E_wr_q   <= '0;
            E_tn_q   <= '0;
            M_wr_q   <= '0;
            M_tn_q   <= '0;
            md_cnt_q <= '0;
        end else begin
            E_wr_q   <= E_wr_d;
            E_tn_q   <= E_tn_d;
            M_wr_q   <= M_wr_d;
            M_tn_q   <= M_tn_d;
            md_cnt_q <= md_cnt_d;
        end
    end

endmodule
